// File: rtl/color_offset_bank.sv
// Bank of per-channel colour offset registers nudged by debounced up/down buttons,
// with press-edge stepping, hold-to-auto-repeat, saturation and a clamp indicator.
module color_offset_bank #(
  parameter int NUM_CH        = 7,
  parameter int OFF_W         = 4,
  parameter int STEP          = 1,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       sel,
  input  logic                    up,
  input  logic                    down,
  input  logic                    clear,
  output logic [NUM_CH*OFF_W-1:0] offsets,
  output logic                    adjusting,
  output logic                    step,
  output logic                    clamped
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EXT_W   = OFF_W + 1;

  localparam logic [EXT_W-1:0] STEP_EXT    = EXT_W'(STEP);
  localparam logic [EXT_W-1:0] MAX_EXT     = {1'b0, {OFF_W{1'b1}}};
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

  state_t            state_reg;
  dir_t              dir;
  dir_t              prev_dir_reg;
  logic [CNT_W-1:0]  counter_reg;
  logic              step_reg;
  logic              clamped_reg;
  logic              step_now;
  logic              fresh_edge;
  logic              held_ok;
  logic              counter_last;
  logic [NUM_CH-1:0] ch_clamp;

  always_comb begin
    dir = DIR_NONE;
    if (up && !down)
      dir = DIR_UP;
    else if (down && !up)
      dir = DIR_DOWN;
  end

  assign adjusting    = |sel;
  assign fresh_edge   = (dir != DIR_NONE) && (dir != prev_dir_reg);
  assign held_ok      = adjusting && (dir != DIR_NONE) && (dir == prev_dir_reg);
  assign counter_last = (counter_reg <= CNT_ONE);

  always_comb begin
    step_now = 1'b0;
    if (!clear) begin
      case (state_reg)
        ST_IDLE:             step_now = fresh_edge && adjusting;
        ST_HOLD, ST_REPEAT:  step_now = held_ok && counter_last;
        default:             step_now = 1'b0;
      endcase
    end
  end

  // Each channel saturates at OFF_W+1 bits so neither direction can wrap.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [OFF_W-1:0] offset_reg;
      logic [EXT_W-1:0] sum_ext;
      logic [EXT_W-1:0] diff_ext;
      logic             sat_up;
      logic             sat_down;
      logic [OFF_W-1:0] stepped;

      assign sum_ext  = {1'b0, offset_reg} + STEP_EXT;
      assign diff_ext = {1'b0, offset_reg} - STEP_EXT;
      assign sat_up   = (sum_ext > MAX_EXT);
      assign sat_down = diff_ext[OFF_W];
      assign stepped  = (dir == DIR_DOWN) ? (sat_down ? '0 : diff_ext[OFF_W-1:0])
                                          : (sat_up ? MAX_EXT[OFF_W-1:0] : sum_ext[OFF_W-1:0]);
      assign ch_clamp[gi] = sel[gi] && ((dir == DIR_DOWN) ? sat_down : sat_up);

      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          offset_reg <= '0;
        else if (clear && sel[gi])
          offset_reg <= '0;
        else if (step_now && sel[gi])
          offset_reg <= stepped;
      end

      assign offsets[gi*OFF_W +: OFF_W] = offset_reg;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      counter_reg  <= '0;
      prev_dir_reg <= DIR_NONE;
      step_reg     <= 1'b0;
      clamped_reg  <= 1'b0;
    end else begin
      step_reg     <= step_now;
      clamped_reg  <= step_now && (|ch_clamp);
      prev_dir_reg <= dir;
      if (clear) begin
        state_reg   <= ST_IDLE;
        counter_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (step_now) begin
              state_reg   <= ST_HOLD;
              counter_reg <= HOLD_LOAD;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (!held_ok) begin
              state_reg   <= ST_IDLE;
              counter_reg <= '0;
              // Forget the old direction so a reversal is seen as a fresh press next cycle.
              if ((dir != DIR_NONE) && (dir != prev_dir_reg))
                prev_dir_reg <= DIR_NONE;
            end else if (counter_last) begin
              state_reg   <= ST_REPEAT;
              counter_reg <= REPEAT_LOAD;
            end else begin
              counter_reg <= counter_reg - CNT_ONE;
            end
          end
          default: begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
          end
        endcase
      end
    end
  end

  assign step    = step_reg;
  assign clamped = clamped_reg;

endmodule

// File: tb/tb_color_offset_bank.sv
// Directed bench for color_offset_bank: expected outputs are queued as each cycle is
// driven and compared after the clock edge that registers it.
module tb_color_offset_bank;

  localparam int NUM_CH = 7;
  localparam int OFF_W  = 4;
  localparam int STEP   = 1;
  localparam int HOLD   = 16;
  localparam int REP    = 4;
  localparam int MAXV   = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  sel   = '0;
  logic        up    = 1'b0;
  logic        down  = 1'b0;
  logic        clear = 1'b0;
  logic [27:0] offsets;
  logic        adjusting;
  logic        step;
  logic        clamped;

  always #5 clock = ~clock;

  color_offset_bank #(
    .NUM_CH(NUM_CH), .OFF_W(OFF_W), .STEP(STEP),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clock(clock), .reset(reset), .sel(sel), .up(up), .down(down), .clear(clear),
    .offsets(offsets), .adjusting(adjusting), .step(step), .clamped(clamped)
  );

  typedef struct packed {
    logic        es;
    logic        ec;
    logic [27:0] eo;
  } exp_t;

  exp_t  exp_q[$];
  int    exp_off[NUM_CH];
  int    passed = 0;
  int    total  = 0;
  string cur_tag = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic logic [27:0] pack_exp();
    logic [27:0] p;
    p = '0;
    for (int i = 0; i < NUM_CH; i++) p[i*OFF_W +: OFF_W] = exp_off[i][OFF_W-1:0];
    return p;
  endfunction

  task automatic model_step(input logic dn, input logic [6:0] s, output logic clamp);
    clamp = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s[i]) begin
        if (!dn) begin
          if (exp_off[i] + STEP > MAXV) begin exp_off[i] = MAXV; clamp = 1'b1; end
          else exp_off[i] = exp_off[i] + STEP;
        end else begin
          if (exp_off[i] - STEP < 0) begin exp_off[i] = 0; clamp = 1'b1; end
          else exp_off[i] = exp_off[i] - STEP;
        end
      end
    end
  endtask

  // One clock cycle of stimulus; es says whether this cycle should apply a step.
  task automatic tick(input logic u, input logic d, input logic c, input logic [6:0] s,
                      input logic es);
    exp_t e;
    logic ec;
    up = u; down = d; clear = c; sel = s;
    ec = 1'b0;
    if (c) begin
      for (int i = 0; i < NUM_CH; i++) if (s[i]) exp_off[i] = 0;
    end else if (es) begin
      model_step(d & ~u, s, ec);
    end
    e.es = es & ~c;
    e.ec = ec;
    e.eo = pack_exp();
    exp_q.push_back(e);
    #1;
    check({cur_tag, "/adjusting"}, 32'(adjusting), 32'(|s));
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check({cur_tag, "/step"},    32'(step),    32'(e.es));
    check({cur_tag, "/clamped"}, 32'(clamped), 32'(e.ec));
    check({cur_tag, "/offsets"}, 32'(offsets), 32'(e.eo));
    $display("%s: up=%0b down=%0b clear=%0b sel=%07b -> offsets=%07h step=%0b clamped=%0b",
             cur_tag, u, d, c, s, offsets, step, clamped);
  endtask

  task automatic press(input logic u, input logic d, input logic [6:0] s);
    tick(u, d, 1'b0, s, 1'b1);
    tick(1'b0, 1'b0, 1'b0, s, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) exp_off[i] = 0;

    cur_tag = "reset";
    repeat (3) @(posedge clock);
    #1;
    check("reset/offsets", 32'(offsets), 32'd0);
    check("reset/step", 32'(step), 32'd0);
    check("reset/clamped", 32'(clamped), 32'd0);
    check("reset/adjusting", 32'(adjusting), 32'd0);
    reset = 1'b0;

    cur_tag = "single_press";
    press(1'b1, 1'b0, 7'b0000001);

    cur_tag = "hold40";
    tick(1'b0, 1'b0, 1'b1, 7'b0000001, 1'b0);
    for (int k = 0; k < 40; k++)
      tick(1'b1, 1'b0, 1'b0, 7'b0000001, (k == 0) || (k >= HOLD && (k - HOLD) % REP == 0));
    tick(1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0);
    check("hold40/ch0", 32'(offsets[3:0]), 32'd7);

    cur_tag = "clamp_up";
    for (int k = 0; k < 7; k++) press(1'b1, 1'b0, 7'b0000001);
    check("clamp_up/ch0_at_14", 32'(offsets[3:0]), 32'd14);
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 7'b0000001);

    cur_tag = "clamp_down";
    tick(1'b0, 1'b0, 1'b1, 7'b0000001, 1'b0);
    press(1'b1, 1'b0, 7'b0000001);
    for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 7'b0000001);

    cur_tag = "multi_sel";
    tick(1'b0, 1'b0, 1'b1, 7'h7F, 1'b0);
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 7'b0000010);
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 7'b0000101);
    for (int k = 0; k < 6; k++) press(1'b1, 1'b0, 7'b0000100);
    press(1'b0, 1'b1, 7'b0000101);
    check("multi_sel/offsets", 32'(offsets), 32'h0000852);

    cur_tag = "both_high";
    for (int k = 0; k < 50; k++) tick(1'b1, 1'b1, 1'b0, 7'b0000101, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 7'b0000101, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 7'b0000101, 1'b0);

    cur_tag = "dir_change";
    tick(1'b1, 1'b0, 1'b0, 7'b0000001, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 7'b0000001, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 7'b0000001, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 7'b0000001, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0);

    cur_tag = "sel_drop";
    tick(1'b1, 1'b0, 1'b0, 7'b0000001, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 1'b0, 7'b0000001, 1'b0);
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 1'b0, 7'b0000000, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0);

    cur_tag = "clear_in_repeat";
    for (int k = 0; k < 18; k++)
      tick(1'b1, 1'b0, 1'b0, 7'b0000101, (k == 0) || (k >= HOLD && (k - HOLD) % REP == 0));
    tick(1'b1, 1'b0, 1'b1, 7'b0000101, 1'b0);
    for (int k = 0; k < 30; k++) tick(1'b1, 1'b0, 1'b0, 7'b0000101, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 7'b0000101, 1'b0);
    press(1'b1, 1'b0, 7'b0000101);

    cur_tag = "reset_mid_hold";
    for (int k = 0; k < 20; k++)
      tick(1'b1, 1'b0, 1'b0, 7'b0000001, (k == 0) || (k >= HOLD && (k - HOLD) % REP == 0));
    reset = 1'b1;
    #2;
    check("reset_mid_hold/offsets_async", 32'(offsets), 32'd0);
    check("reset_mid_hold/step_async", 32'(step), 32'd0);
    check("reset_mid_hold/clamped_async", 32'(clamped), 32'd0);
    for (int i = 0; i < NUM_CH; i++) exp_off[i] = 0;
    up = 1'b0;
    @(posedge clock);
    #1;
    check("reset_mid_hold/offsets_held", 32'(offsets), 32'd0);
    check("reset_mid_hold/step_held", 32'(step), 32'd0);
    reset = 1'b0;
    press(1'b1, 1'b0, 7'b0000001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
